// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the 64-bit register-file/ALU datapath.
// Takes one 16-bit instruction at a time and drives the datapath controls.
module datapath_sequencer #(
    parameter int WB_LAT     = 1,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [7:0]  Ctrl,
    output logic [3:0]  Sel,
    output logic        Wen,
    output logic [3:0]  WA,
    output logic [3:0]  RAA,
    output logic [3:0]  RAB,
    output logic [2:0]  Op,
    input  logic        Flag,
    output logic        busy_o,
    output logic        skip_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    localparam logic [2:0] LAST_EXEC = 3'(WB_LAT - 1);
    localparam logic [2:0] SUB_LOAD  = 3'b000;
    localparam logic [2:0] SUB_SKIPZ = 3'b001;
    localparam logic [2:0] SUB_NOP   = 3'b010;
    localparam logic [2:0] SUB_OUT   = 3'b011;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        skip_pend_q, skip_pend_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        skip_q, skip_d;
    logic        err_q, err_d;

    logic       is_ctrl;
    logic [2:0] subop;
    logic       is_alu;
    logic       is_load;
    logic       handshake;

    assign is_ctrl   = instr_q[15];
    assign subop     = instr_q[14:12];
    assign is_alu    = !is_ctrl;
    assign is_load   = is_ctrl && (subop == SUB_LOAD);
    assign handshake = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            cnt_q       <= '0;
            skip_pend_q <= 1'b0;
            ctrl_q      <= '0;
            skip_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            skip_pend_q <= skip_pend_d;
            ctrl_q      <= ctrl_d;
            skip_q      <= skip_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        skip_pend_d = skip_pend_q;
        ctrl_d      = ctrl_q;
        skip_d      = 1'b0;
        err_d       = ERR_STICKY ? err_q : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    // A pending skip swallows this instruction without decoding it.
                    if (skip_pend_q) begin
                        skip_pend_d = 1'b0;
                        skip_d      = 1'b1;
                    end else begin
                        instr_d = instr_i;
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (is_alu || is_load) begin
                    if (cnt_q == LAST_EXEC) begin
                        state_d = S_WB;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                    case (subop)
                        SUB_SKIPZ: if (Flag) skip_pend_d = 1'b1;
                        SUB_NOP:   ;
                        SUB_OUT:   ctrl_d = instr_q[7:0];
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            S_WB: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready_o = (state_q == S_IDLE) && !rst;
        busy_o        = (state_q != S_IDLE);
        Ctrl          = ctrl_q;
        skip_o        = skip_q;
        err_o         = err_q;
        Sel           = '0;
        Wen           = 1'b0;
        WA            = '0;
        RAA           = '0;
        RAB           = '0;
        Op            = '0;
        if (state_q == S_EXEC || state_q == S_WB) begin
            if (is_alu) begin
                Op  = instr_q[14:12];
                WA  = instr_q[11:8];
                RAA = instr_q[7:4];
                RAB = instr_q[3:0];
            end else if (is_load) begin
                WA  = instr_q[11:8];
                Sel = instr_q[3:0];
            end
        end
        Wen = (state_q == S_WB);
    end

endmodule
